// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prog_loader_pkg;

    localparam int         PL_LEN_W     = 16;
    localparam logic [7:0] PL_MAGIC_DEF = 8'hA5;

    typedef logic [PL_LEN_W-1:0] pl_len_t;

    // The checksum state only exists when the checksum byte is part of the frame.
    typedef enum logic [2:0] {
        PL_IDLE   = 3'd0,
        PL_LEN_HI = 3'd1,
        PL_LEN_LO = 3'd2,
        PL_DATA   = 3'd3,
`ifdef PROG_LOADER_CKSUM_EN
        PL_CKSUM  = 3'd4,
`endif
        PL_DONE   = 3'd5
    } pl_state_t;

endpackage

// File: rtl/prog_loader_cksum.sv
// 8-bit modulo-256 running sum of payload bytes; sum_ok flags that sum + din wraps to zero.
// Latency: sum updates 1 cycle after add_en; sum_ok is combinational on din.
// Backpressure: none, consumes one byte per cycle when add_en is high.
module prog_loader_cksum
    import prog_loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       add_en,
    input  logic [7:0] din,
    output logic       sum_ok
);

    logic [7:0] sum;

    // Accumulate payload bytes; a clear wins over an add in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= 8'h00;
        end else if (clr) begin
            sum <= 8'h00;
        end else if (add_en) begin
            sum <= sum + din;
        end
    end

    assign sum_ok = (8'(sum + din) == 8'h00);

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader (magic, len16, payload[, checksum]) writing program memory from address 0; optional checksum under PROG_LOADER_CKSUM_EN.
// Latency: memory write and status (busy/err/cpu_run) registered, 1 cycle after the byte is accepted.
// Backpressure: none, in_ready is 1 in every state after reset, one byte per cycle.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         ADDR_W = 10,
    parameter logic [7:0] MAGIC  = PL_MAGIC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              err,
    output logic              cpu_run
);

    // Largest legal payload; the counter is one bit wider so this length does not alias to 0.
    localparam pl_len_t MAX_LEN = pl_len_t'(2 ** ADDR_W);

    pl_state_t   state;
    logic [7:0]  len_hi;
    pl_len_t     len_q;
    logic [ADDR_W:0] cnt;

    logic    accept;
    logic    magic_hit;
    pl_len_t len_full;
    logic    len_bad;
    logic    last_byte;

    assign accept    = in_valid && in_ready;
    assign magic_hit = accept && (in_data == MAGIC) && ((state == PL_IDLE) || (state == PL_DONE));
    assign len_full  = {len_hi, in_data};
    assign len_bad   = (len_full == '0) || (len_full > MAX_LEN);
    assign last_byte = ((pl_len_t'(cnt) + pl_len_t'(1)) == len_q);

`ifdef PROG_LOADER_CKSUM_EN
    logic sum_ok;

    prog_loader_cksum u_cksum (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (magic_hit),
        .add_en (accept && (state == PL_DATA)),
        .din    (in_data),
        .sum_ok (sum_ok)
    );
`endif

    // Frame parser: state, counters and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PL_IDLE;
            len_hi    <= 8'h00;
            len_q     <= '0;
            cnt       <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            busy      <= 1'b0;
            err       <= 1'b0;
            cpu_run   <= 1'b0;
        end else begin
            in_ready <= 1'b1;
            mem_we   <= 1'b0;
            if (accept) begin
                case (state)
                    PL_IDLE, PL_DONE: begin
                        if (magic_hit) begin
                            state   <= PL_LEN_HI;
                            busy    <= 1'b1;
                            err     <= 1'b0;
                            cpu_run <= 1'b0;
                            cnt     <= '0;
                        end
                    end
                    PL_LEN_HI: begin
                        len_hi <= in_data;
                        state  <= PL_LEN_LO;
                    end
                    PL_LEN_LO: begin
                        if (len_bad) begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            state <= PL_IDLE;
                        end else begin
                            len_q <= len_full;
                            state <= PL_DATA;
                        end
                    end
                    PL_DATA: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= cnt[ADDR_W-1:0];
                        mem_wdata <= in_data;
                        cnt       <= cnt + 1'b1;
                        if (last_byte) begin
`ifdef PROG_LOADER_CKSUM_EN
                            state <= PL_CKSUM;
`else
                            state   <= PL_DONE;
                            cpu_run <= 1'b1;
                            busy    <= 1'b0;
`endif
                        end
                    end
`ifdef PROG_LOADER_CKSUM_EN
                    PL_CKSUM: begin
                        busy <= 1'b0;
                        if (sum_ok) begin
                            state   <= PL_DONE;
                            cpu_run <= 1'b1;
                        end else begin
                            state   <= PL_IDLE;
                            err     <= 1'b1;
                            cpu_run <= 1'b0;
                        end
                    end
`endif
                    default: state <= PL_IDLE;
                endcase
            end
        end
    end

endmodule
